// File: rtl/led_mem_arbiter_if.sv
// Requester, memory-port and debug signals of the two-requester LED memory arbiter.
// Handshake: a requester holds req/we/addr/wdata/lock stable while req=1 and ack=0; the transfer
// happens on the rising edge where req&ack, after which the next request may be presented.
interface led_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_lock;
    logic              r0_ack;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_lock;
    logic              r1_ack;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_ena;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dina;
    logic [DATA_W-1:0] mem_douta;

    logic              owner;
    logic [1:0]        lock_state;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        input  mem_douta,
        output r0_ack, r0_rvalid, r0_rdata,
        output r1_ack, r1_rvalid, r1_rdata,
        output mem_ena, mem_wea, mem_addr, mem_dina,
        output owner, lock_state
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
        output mem_douta,
        input  r0_ack, r0_rvalid, r0_rdata,
        input  r1_ack, r1_rvalid, r1_rdata,
        input  mem_ena, mem_wea, mem_addr, mem_dina,
        input  owner, lock_state
    );
endinterface

// File: rtl/led_mem_arbiter.sv
// Round-robin arbiter with bounded burst lock in front of the single-port 16x16 LED block memory.
// Registers the winning access onto the memory port and routes read data back to its issuer.
module led_mem_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input logic           clk_fnl,
    input logic           rst,
    led_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_R0   = 2'd1,
        LOCK_R1   = 2'd2
    } lock_t;

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    lock_t             lock_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ptr_q;
    logic              owner_q;
    logic              ena_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dina_q;
    logic              rv0_q;
    logic              rv1_q;

    logic              both_req;
    logic              burst_done;
    logic              grant1;
    logic              xfer;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    lock_t             win_id;

    // grant1 selects requester 1; a lock only matters while both sides are requesting
    always_comb begin
        both_req   = bus.r0_req & bus.r1_req;
        burst_done = (cnt_q == CNT_W'(BURST_MAX));
        grant1     = bus.r1_req;
        if (both_req) begin
            case (lock_q)
                LOCK_R0: grant1 = burst_done;
                LOCK_R1: grant1 = !burst_done;
                default: grant1 = ptr_q;
            endcase
        end
    end

    assign xfer       = (bus.r0_req | bus.r1_req) & ~rst;
    assign bus.r0_ack = xfer & ~grant1;
    assign bus.r1_ack = xfer & grant1;

    assign win_we    = grant1 ? bus.r1_we    : bus.r0_we;
    assign win_lock  = grant1 ? bus.r1_lock  : bus.r0_lock;
    assign win_addr  = grant1 ? bus.r1_addr  : bus.r0_addr;
    assign win_wdata = grant1 ? bus.r1_wdata : bus.r0_wdata;
    assign win_id    = grant1 ? LOCK_R1      : LOCK_R0;

    always_ff @(posedge clk_fnl or posedge rst) begin
        if (rst) begin
            lock_q  <= LOCK_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            addr_q  <= '0;
            dina_q  <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            // owner_q still names the issuer of the access the memory samples on this edge
            rv0_q <= ena_q & ~wea_q & ~owner_q;
            rv1_q <= ena_q & ~wea_q & owner_q;
            ena_q <= xfer;
            wea_q <= xfer & win_we;
            if (xfer) begin
                addr_q  <= win_addr;
                dina_q  <= win_wdata;
                owner_q <= grant1;
                ptr_q   <= ~grant1;
                lock_q  <= win_lock ? win_id : LOCK_IDLE;
                if (lock_q == win_id) begin
                    if (!burst_done) cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= CNT_W'(1);
                end
            end
        end
    end

    assign bus.mem_ena    = ena_q;
    assign bus.mem_wea    = wea_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_dina   = dina_q;
    assign bus.owner      = owner_q;
    assign bus.lock_state = lock_q;
    assign bus.r0_rvalid  = rv0_q;
    assign bus.r1_rvalid  = rv1_q;
    assign bus.r0_rdata   = bus.mem_douta;
    assign bus.r1_rdata   = bus.mem_douta;
endmodule

// File: tb/tb_led_mem_arbiter.sv
// Randomized bench for led_mem_arbiter: a rule-level arbitration model, a shadow memory and a
// read-return queue predict acks, memory-port values and read data every cycle.
module tb_led_mem_arbiter;
    localparam int BURST_MAX = 4;
    localparam int M_WRITE = 0;
    localparam int M_FAIR  = 1;
    localparam int M_BURST = 2;
    localparam int M_RAND  = 3;

    logic clk_fnl;
    logic rst;

    led_mem_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    led_mem_arbiter #(.ADDR_W(4), .DATA_W(16), .BURST_MAX(BURST_MAX)) dut (
        .clk_fnl (clk_fnl),
        .rst     (rst),
        .bus     (bus)
    );

    // clock / reset
    initial clk_fnl = 1'b0;
    always #5 clk_fnl = ~clk_fnl;

    // requester drive values
    logic        req_v   [2];
    logic        we_v    [2];
    logic        lock_v  [2];
    logic [3:0]  addr_v  [2];
    logic [15:0] wdata_v [2];
    bit          acked   [2];

    assign bus.r0_req   = req_v[0];
    assign bus.r0_we    = we_v[0];
    assign bus.r0_lock  = lock_v[0];
    assign bus.r0_addr  = addr_v[0];
    assign bus.r0_wdata = wdata_v[0];
    assign bus.r1_req   = req_v[1];
    assign bus.r1_we    = we_v[1];
    assign bus.r1_lock  = lock_v[1];
    assign bus.r1_addr  = addr_v[1];
    assign bus.r1_wdata = wdata_v[1];

    // block memory behaviour: read-first, one cycle of read latency
    logic [15:0] ram [16];
    logic [15:0] douta_r;
    always @(posedge clk_fnl) begin
        if (bus.mem_ena) begin
            if (bus.mem_wea) ram[bus.mem_addr] <= bus.mem_dina;
            douta_r <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_douta = douta_r;

    // reference model
    int          m_ptr;
    int          m_lock;
    int          m_run;
    int          m_owner;
    bit          e_ena;
    bit          e_wea;
    logic [3:0]  e_addr;
    logic [15:0] e_dina;
    logic [15:0] shadow [16];
    logic [16:0] exp_q [$];
    int          due_q [$];
    int          cyc;
    int          wr_idx;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic q0, input logic q1);
        if (!q0 && !q1) return -1;
        if (q0 != q1) return q0 ? 0 : 1;
        if (m_lock < 0) return m_ptr;
        return (m_run < BURST_MAX) ? m_lock : 1 - m_lock;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_lock = -1; m_run = 0; m_owner = 0;
        e_ena = 0; e_wea = 0; e_addr = '0; e_dina = '0;
        exp_q.delete();
        due_q.delete();
        acked[0] = 0; acked[1] = 0;
    endtask

    // one clock: check at negedge, advance model at posedge, return 1ns after the edge
    task automatic step();
        int w;
        bit rv0, rv1;
        @(negedge clk_fnl);
        w = pick(req_v[0], req_v[1]);
        check_eq("r0_ack", bus.r0_ack, w == 0);
        check_eq("r1_ack", bus.r1_ack, w == 1);
        check_eq("mem_ena", bus.mem_ena, e_ena);
        check_eq("mem_wea", bus.mem_wea, e_wea);
        check_eq("mem_addr", bus.mem_addr, e_addr);
        check_eq("mem_dina", bus.mem_dina, e_dina);
        check_eq("owner", bus.owner, m_owner);
        rv0 = 0; rv1 = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            if (exp_q[0][16]) rv1 = 1;
            else rv0 = 1;
        end
        check_eq("r0_rvalid", bus.r0_rvalid, rv0);
        check_eq("r1_rvalid", bus.r1_rvalid, rv1);
        if (rv0 || rv1) begin
            check_eq("rdata", exp_q[0][16] ? bus.r1_rdata : bus.r0_rdata, exp_q[0][15:0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end
        @(posedge clk_fnl);
        cyc++;
        acked[0] = (w == 0);
        acked[1] = (w == 1);
        e_ena = (w >= 0);
        e_wea = 0;
        if (w >= 0) begin
            e_wea  = we_v[w];
            e_addr = addr_v[w];
            e_dina = wdata_v[w];
            if (we_v[w]) begin
                shadow[addr_v[w]] = wdata_v[w];
            end else begin
                exp_q.push_back({w[0], shadow[addr_v[w]]});
                due_q.push_back(cyc + 1);
            end
            m_run   = (m_lock == w) ? ((m_run < BURST_MAX) ? m_run + 1 : BURST_MAX) : 1;
            m_lock  = lock_v[w] ? w : -1;
            m_ptr   = 1 - w;
            m_owner = w;
        end
        #1;
    endtask

    // driver
    task automatic new_op(input int r, input int mode);
        req_v[r]   = 1'b1;
        lock_v[r]  = 1'b0;
        we_v[r]    = 1'($urandom_range(0, 1));
        addr_v[r]  = 4'($urandom_range(0, 15));
        wdata_v[r] = 16'($urandom);
        case (mode)
            M_WRITE: begin
                if (r == 0 && wr_idx < 16) begin
                    we_v[r]    = 1'b1;
                    addr_v[r]  = 4'(wr_idx);
                    wdata_v[r] = 16'hFFFF;
                    wr_idx++;
                end else begin
                    req_v[r] = 1'b0;
                end
            end
            M_FAIR:  ;
            M_BURST: lock_v[r] = (r == 0);
            default: begin
                req_v[r]  = ($urandom_range(0, 3) != 0);
                lock_v[r] = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic run(input int mode, input int n);
        repeat (n) begin
            for (int r = 0; r < 2; r++)
                if (!req_v[r] || acked[r]) new_op(r, mode);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        for (int r = 0; r < 2; r++) begin
            req_v[r]   = 1'b1;
            we_v[r]    = 1'b1;
            lock_v[r]  = 1'b0;
            addr_v[r]  = 4'($urandom_range(0, 15));
            wdata_v[r] = 16'($urandom);
        end
        repeat (3) begin
            @(negedge clk_fnl);
            check_eq("rst_r0_ack", bus.r0_ack, 0);
            check_eq("rst_r1_ack", bus.r1_ack, 0);
            check_eq("rst_mem_ena", bus.mem_ena, 0);
            check_eq("rst_mem_wea", bus.mem_wea, 0);
            check_eq("rst_r0_rvalid", bus.r0_rvalid, 0);
            check_eq("rst_r1_rvalid", bus.r1_rvalid, 0);
            check_eq("rst_owner", bus.owner, 0);
        end
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_dina", bus.mem_dina, 0);
        check_eq("rst_lock_state", bus.lock_state, 0);
        @(posedge clk_fnl);
        #1;
        rst = 1'b0;
    endtask

    // stimulus and final report
    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; wr_idx = 0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        rst = 1'b1;
        do_reset();

        run(M_WRITE, 20);

        // write A5A5 to address 3, then read it back from requester 1
        req_v[0] = 1; we_v[0] = 1; addr_v[0] = 4'd3; wdata_v[0] = 16'hA5A5; lock_v[0] = 0;
        req_v[1] = 0;
        step();
        req_v[0] = 0;
        req_v[1] = 1; we_v[1] = 0; addr_v[1] = 4'd3; lock_v[1] = 0;
        step();
        req_v[1] = 0;
        repeat (3) step();

        run(M_FAIR, 12);
        run(M_BURST, 15);
        run(M_RAND, 300);

        // read in flight when reset hits must never return
        req_v[0] = 0;
        req_v[1] = 1; we_v[1] = 0; addr_v[1] = 4'd5; lock_v[1] = 0;
        step();
        do_reset();
        run(M_RAND, 100);
        req_v[0] = 0; req_v[1] = 0;
        repeat (4) step();

        check_eq("read_queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
